// File: rtl/bus_pkg.sv
// bus_pkg: shared packet-format constants and helpers for the bus FIFO slice.
package bus_pkg;

    localparam int DEST_W  = 8;
    localparam int STATS_W = 16;
    localparam logic [DEST_W-1:0] BROADCAST = 8'hFF;

    // Destination ID lives in the top byte of a 32-bit packet.
    function automatic logic [DEST_W-1:0] dest_of(input logic [31:0] pkt);
        return pkt[31 -: DEST_W];
    endfunction

endpackage

// File: rtl/bus_fifo_mem.sv
// bus_fifo_mem: depth x pckg_sz register array, one synchronous write port,
// one asynchronous read port.
module bus_fifo_mem #(
    parameter int pckg_sz = 32,
    parameter int depth   = 8,
    localparam int PTR_W  = $clog2(depth)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [PTR_W-1:0]   waddr,
    input  logic [pckg_sz-1:0] wdata,
    input  logic [PTR_W-1:0]   raddr,
    output logic [pckg_sz-1:0] rdata
);

    logic [pckg_sz-1:0] mem [depth];

    // NOTE: storage has no reset; pndng gates the head, so stale contents are never visible.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/bus_dev_fifo.sv
// bus_dev_fifo: per-device transmit FIFO with show-ahead head word and sticky overflow.
// Optional hwm/drop_cnt statistics are built only when FIFO_STATS_EN is defined.
module bus_dev_fifo
    import bus_pkg::*;
#(
    parameter int pckg_sz = 32,
    parameter int depth   = 8,
    localparam int cnt_w  = $clog2(depth + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_in,
    input  logic [pckg_sz-1:0] D_in,
    output logic               full,
    output logic               pndng,
    input  logic               pop,
    output logic [pckg_sz-1:0] D_pop,
    output logic [cnt_w-1:0]   count,
    output logic               overflow,
    output logic [cnt_w-1:0]   hwm,
    output logic [STATS_W-1:0] drop_cnt
);

    localparam int PTR_W = $clog2(depth);

    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [cnt_w-1:0]   count_next;
    logic [pckg_sz-1:0] head;
    logic               wr_ok;
    logic               rd_ok;
    logic               drop;

    assign full  = (count == cnt_w'(depth));
    assign pndng = (count != '0);

    // A pop frees the slot the simultaneous push needs, so full & push & pop is legal.
    assign rd_ok      = pop & pndng;
    assign wr_ok      = push_in & (~full | pop);
    assign drop       = push_in & full & ~pop;
    assign count_next = count + cnt_w'(wr_ok) - cnt_w'(rd_ok);

    bus_fifo_mem #(
        .pckg_sz (pckg_sz),
        .depth   (depth)
    ) u_mem (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (wr_ptr),
        .wdata (D_in),
        .raddr (rd_ptr),
        .rdata (head)
    );

    assign D_pop = pndng ? head : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rd_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_next;
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

`ifdef FIFO_STATS_EN
    logic [cnt_w-1:0]   hwm_q;
    logic [STATS_W-1:0] drop_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hwm_q  <= '0;
            drop_q <= '0;
        end else begin
            if (count_next > hwm_q) begin
                hwm_q <= count_next;
            end
            if (drop && (drop_q != '1)) begin
                drop_q <= drop_q + STATS_W'(1);
            end
        end
    end

    assign hwm      = hwm_q;
    assign drop_cnt = drop_q;
`else
    assign hwm      = '0;
    assign drop_cnt = '0;
`endif

endmodule
